// File: rtl/hash_alu_sequencer.sv
// Block-hash sequencer: feeds a byte stream through the shared ALU's muladdmod op
// and emits one hash per win_len-byte block, always yielding the ALU to the CPU.
module hash_alu_sequencer #(
    parameter int         CNT_W         = 5,
    parameter logic [3:0] MULADDMOD_CTL = 4'd10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_last,
    output logic             byte_ready,
    input  logic             cpu_alu_req,
    output logic             alu_own,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       aluctl_seq,
    input  logic [31:0]      alu_result,
    output logic [31:0]      hash_out,
    output logic             hash_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, WAIT_BYTE, ISSUE, EMIT, FINISH} state_t;

    state_t           state;
    logic [CNT_W-1:0] win_len_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      acc;
    logic [7:0]       byte_q;
    logic             last_q;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_len_q <= '0;
            cnt       <= '0;
            acc       <= '0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            hash_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (win_len != '0) begin
                            win_len_q <= win_len;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= WAIT_BYTE;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                WAIT_BYTE: begin
                    if (byte_valid) begin
                        byte_q <= byte_in;
                        last_q <= byte_last;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // CPU request stalls here indefinitely; accumulator holds.
                    if (!cpu_alu_req) begin
                        acc <= alu_result;
                        cnt <= cnt_inc;
                        if (cnt_inc == win_len_q || last_q) begin
                            hash_out <= alu_result;
                            state    <= EMIT;
                        end else begin
                            state <= WAIT_BYTE;
                        end
                    end
                end
                EMIT: begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= last_q ? FINISH : WAIT_BYTE;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready = (state == WAIT_BYTE);
    assign hash_valid = (state == EMIT);
    assign done       = (state == FINISH);
    assign busy       = (state != IDLE);

    // Operands are zeroed whenever the CPU owns the ALU so the mux stays clean.
    assign alu_own    = (state == ISSUE) && !cpu_alu_req;
    assign alu_a      = alu_own ? acc : 32'd0;
    assign alu_b      = alu_own ? {24'd0, byte_q} : 32'd0;
    assign aluctl_seq = alu_own ? MULADDMOD_CTL : 4'd0;

endmodule

// File: tb/tb_hash_alu_sequencer.sv
// Directed bench for hash_alu_sequencer with a small muladdmod ALU model (base 256, mod 251).
module tb_hash_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  win_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic        cpu_alu_req;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  aluctl_seq;
    logic [31:0] alu_result;
    logic [31:0] hash_out;
    logic        hash_valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int hv_cnt = 0;
    int done_cnt = 0;
    logic [31:0] hq[$];

    always #5 clk = ~clk;

    hash_alu_sequencer #(.CNT_W(5), .MULADDMOD_CTL(4'd10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .cpu_alu_req(cpu_alu_req), .alu_own(alu_own),
        .alu_a(alu_a), .alu_b(alu_b), .aluctl_seq(aluctl_seq),
        .alu_result(alu_result), .hash_out(hash_out), .hash_valid(hash_valid),
        .busy(busy), .done(done)
    );

    logic [63:0] alu_wide;
    assign alu_wide   = ({32'd0, alu_a} * 64'd256 + {32'd0, alu_b}) % 64'd251;
    assign alu_result = (aluctl_seq == 4'd10) ? alu_wide[31:0] : 32'd0;

    always @(negedge clk) begin
        if (rst_n && hash_valid) begin
            hv_cnt++;
            hq.push_back(hash_out);
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mon();
        hv_cnt = 0;
        done_cnt = 0;
        hq.delete();
    endtask

    task automatic start_job(input logic [4:0] wl);
        start = 1'b1;
        win_len = wl;
        tick();
        start = 1'b0;
    endtask

    // Returns at the negedge where the DUT sits in ISSUE with this byte.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        chk("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b1;
        byte_in = b;
        byte_last = last;
        tick();
        byte_valid = 1'b0;
        byte_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        win_len = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        cpu_alu_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_hv", {31'd0, hash_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_own", {31'd0, alu_own}, 32'd0);
        chk("rst_hash", hash_out, 32'd0);
        chk("rst_ctl", {28'd0, aluctl_seq}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two-byte block, cycle by cycle.
        clear_mon();
        start_job(5'd2);
        chk("t1_ready", {31'd0, byte_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h01, 1'b0);
        chk("t1_own0", {31'd0, alu_own}, 32'd1);
        chk("t1_a0", alu_a, 32'd0);
        chk("t1_b0", alu_b, 32'd1);
        chk("t1_ctl0", {28'd0, aluctl_seq}, 32'd10);
        tick();
        chk("t1_ready1", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h02, 1'b1);
        chk("t1_a1", alu_a, 32'd1);
        chk("t1_b1", alu_b, 32'd2);
        tick();
        chk("t1_hv", {31'd0, hash_valid}, 32'd1);
        chk("t1_hash", hash_out, 32'd7);
        tick();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_hv_off", {31'd0, hash_valid}, 32'd0);
        tick();
        chk("t1_busy_off", {31'd0, busy}, 32'd0);
        chk("t1_hvcnt", hv_cnt, 32'd1);
        chk("t1_donecnt", done_cnt, 32'd1);

        // Full block followed by a partial block.
        clear_mon();
        start_job(5'd2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        wait_idle();
        chk("t2_hvcnt", hv_cnt, 32'd2);
        chk("t2_h0", hq[0], 32'd7);
        chk("t2_h1", hq[1], 32'd3);
        chk("t2_donecnt", done_cnt, 32'd1);

        // CPU stall of five cycles during the first ISSUE.
        clear_mon();
        start_job(5'd2);
        send_byte(8'h01, 1'b0);
        cpu_alu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_own_stall", {31'd0, alu_own}, 32'd0);
            chk("t3_ctl_stall", {28'd0, aluctl_seq}, 32'd0);
            chk("t3_a_stall", alu_a, 32'd0);
            tick();
        end
        cpu_alu_req = 1'b0;
        #1;
        chk("t3_own_resume", {31'd0, alu_own}, 32'd1);
        chk("t3_a_resume", alu_a, 32'd0);
        chk("t3_b_resume", alu_b, 32'd1);
        send_byte(8'h02, 1'b1);
        chk("t3_a1", alu_a, 32'd1);
        wait_idle();
        chk("t3_hvcnt", hv_cnt, 32'd1);
        chk("t3_hash", hq[0], 32'd7);

        // Zero-length job.
        clear_mon();
        start_job(5'd0);
        #1;
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_ready", {31'd0, byte_ready}, 32'd0);
        tick();
        chk("t4_done_off", {31'd0, done}, 32'd0);
        chk("t4_busy_off", {31'd0, busy}, 32'd0);
        chk("t4_hvcnt", hv_cnt, 32'd0);

        // Async reset in the middle of the second ISSUE.
        clear_mon();
        start_job(5'd2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_own", {31'd0, alu_own}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_a", alu_a, 32'd0);
        chk("t5_hash", hash_out, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_hvcnt", hv_cnt, 32'd0);
        chk("t5_donecnt", done_cnt, 32'd0);
        start_job(5'd2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        wait_idle();
        chk("t5_fresh", hq[0], 32'd7);

        // start and byte_valid asserted during EMIT must be ignored.
        clear_mon();
        start_job(5'd2);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        tick();
        chk("t6_hv", {31'd0, hash_valid}, 32'd1);
        chk("t6_hash", hash_out, 32'd31);
        start = 1'b1;
        win_len = 5'd1;
        byte_valid = 1'b1;
        byte_in = 8'h09;
        byte_last = 1'b0;
        tick();
        start = 1'b0;
        chk("t6_ready", {31'd0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
        chk("t6_a", alu_a, 32'd0);
        chk("t6_b", alu_b, 32'd9);
        send_byte(8'h0a, 1'b1);
        wait_idle();
        chk("t6_hvcnt", hv_cnt, 32'd2);
        chk("t6_h1", hq[1], 32'd55);
        chk("t6_donecnt", done_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
